// File: rtl/pulse_generator.sv
// pulse_generator: turns single-cycle event strobes into timed output pulses.
// Each strobe produces one PULSE_LEN-cycle high pulse, and consecutive pulses are
// separated by at least GAP_LEN low cycles. Strobes that arrive while a pulse or gap
// is in progress are queued in a saturating pending counter. A sticky overflow flag
// records any strobe that was dropped because the queue was full.
module pulse_generator #(
  parameter int PULSE_LEN   = 4,
  parameter int GAP_LEN     = 2,
  parameter int MAX_PENDING = 3,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              trig,
  input  logic              clr_overflow,
  output logic              signal_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // The duration counter must be wide enough for the longer of the two phases.
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  // The counter is loaded with LEN-1 on entry and the phase ends when it reads zero.
  localparam logic [CNT_W-1:0]  PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_RELOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_FULL    = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE     = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [PEND_W-1:0] pending_next;
  logic              overflow_next;
  logic              pend_inc;
  logic              pend_dec;
  logic              overflow_set;

  // Phase sequencing: decides the next state and duration count, and whether this cycle
  // adds a strobe to the queue or takes one out of it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (trig) begin
          state_next = HIGH;
          cnt_next   = PULSE_RELOAD;
        end
      end
      HIGH: begin
        pend_inc = trig;
        if (cnt == '0) begin
          state_next = GAP;
          cnt_next   = GAP_RELOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (pending != '0) begin
            state_next = HIGH;
            cnt_next   = PULSE_RELOAD;
            pend_dec   = 1'b1;
            pend_inc   = trig;
          end else if (trig) begin
            state_next = HIGH;
            cnt_next   = PULSE_RELOAD;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
          pend_inc = trig;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Queue bookkeeping: a matched add and take leaves the count alone even when full,
  // and an add into a full queue is dropped and flagged instead of wrapping.
  always_comb begin
    pending_next = pending;
    overflow_set = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pending == PEND_FULL) begin
        overflow_set = 1'b1;
      end else begin
        pending_next = pending + PEND_ONE;
      end
    end else if (pend_dec && !pend_inc) begin
      pending_next = pending - PEND_ONE;
    end
    if (overflow_set) begin
      overflow_next = 1'b1;
    end else if (clr_overflow) begin
      overflow_next = 1'b0;
    end else begin
      overflow_next = overflow;
    end
  end

  // All state and outputs are flops; the outputs are decoded from the next state so they
  // line up with the state register without an extra cycle of delay.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      signal_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pending    <= pending_next;
      overflow   <= overflow_next;
      signal_out <= (state_next == HIGH);
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed scenarios for pulse_generator with a pulse scoreboard.
// Cycle n is the nth rising edge after reset release; inputs for cycle n are driven and
// outputs "at cycle n" are observed on the falling edge just before rising edge n.
module tb_pulse_generator;

  localparam int PULSE_LEN   = 4;
  localparam int GAP_LEN     = 2;
  localparam int MAX_PENDING = 3;
  localparam int PEND_W      = $clog2(MAX_PENDING + 1);

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              trig = 1'b0;
  logic              clr_overflow = 1'b0;
  logic              signal_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  pulse_generator #(
    .PULSE_LEN  (PULSE_LEN),
    .GAP_LEN    (GAP_LEN),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .trig        (trig),
    .clr_overflow(clr_overflow),
    .signal_out  (signal_out),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  // Free-running clock, period 10.
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  typedef struct {
    int cyc;
    int what;
    int val;
  } chk_t;

  pulse_t exp_q[$];
  chk_t   chk_q[$];
  pulse_t mon_exp;
  int     cyc;
  int     n_checks = 0;
  int     n_fail = 0;
  logic   prev_sig = 1'b0;
  bit     in_pulse = 1'b0;
  int     rise_cyc = 0;

  // Count rising edges since reset release so every check can name its cycle.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic string what_name(input int what);
    case (what)
      0:       return "signal_out";
      1:       return "busy";
      2:       return "pending";
      default: return "overflow";
    endcase
  endfunction

  function automatic int what_value(input int what);
    case (what)
      0:       return int'(signal_out);
      1:       return int'(busy);
      2:       return int'(pending);
      default: return int'(overflow);
    endcase
  endfunction

  task automatic expect_at(input int c, input int what, input int val);
    chk_t ch;
    ch.cyc  = c;
    ch.what = what;
    ch.val  = val;
    chk_q.push_back(ch);
  endtask

  task automatic expect_pulse(input int start);
    pulse_t p;
    p.start = start;
    p.len   = PULSE_LEN;
    exp_q.push_back(p);
  endtask

  // Scoreboard monitor: measures every completed output pulse and compares it with the
  // oldest expected pulse; a pulse cut short by reset is discarded.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      in_pulse = 1'b0;
      prev_sig = 1'b0;
    end else begin
      if (signal_out && !prev_sig) begin
        in_pulse = 1'b1;
        rise_cyc = cyc + 1;
      end else if (!signal_out && prev_sig && in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected pulse start", rise_cyc, -1);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput($sformatf("pulse start (exp %0d)", mon_exp.start), rise_cyc, mon_exp.start);
          checkOutput($sformatf("pulse length (start %0d)", mon_exp.start),
                      cyc + 1 - rise_cyc, mon_exp.len);
        end
      end
      prev_sig = signal_out;
    end
  end

  task automatic doReset();
    sys_rst      = 1'b1;
    trig         = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Runs cycles 1..n_cycles from the falling edge where reset was released: checks the
  // queued expectations for each cycle, then drives that cycle's inputs.
  task automatic applyStimulus(input logic [63:0] trig_map, input logic [63:0] clr_map,
                               input int n_cycles);
    for (int n = 1; n <= n_cycles; n++) begin
      if (n > 1) @(negedge sys_clk);
      foreach (chk_q[i]) begin
        if (chk_q[i].cyc == n) begin
          checkOutput($sformatf("%s@%0d", what_name(chk_q[i].what), n),
                      what_value(chk_q[i].what), chk_q[i].val);
        end
      end
      trig         = trig_map[n];
      clr_overflow = clr_map[n];
    end
    trig         = 1'b0;
    clr_overflow = 1'b0;
    chk_q.delete();
  endtask

  task automatic checkDrained(input string test_name);
    checkOutput($sformatf("%s pulses outstanding", test_name), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Hard time limit so the bench always ends even if the design hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] tm;
    logic [63:0] cm;

    // Test 1: single strobe, plus reset values at cycle 1.
    doReset();
    tm = '0; cm = '0;
    tm[10] = 1'b1;
    expect_at(1, 0, 0); expect_at(1, 1, 0); expect_at(1, 2, 0); expect_at(1, 3, 0);
    expect_at(10, 0, 0); expect_at(11, 0, 1); expect_at(14, 0, 1);
    expect_at(15, 0, 0); expect_at(16, 0, 0);
    expect_at(11, 1, 1); expect_at(16, 1, 1); expect_at(17, 1, 0);
    expect_at(12, 2, 0); expect_at(15, 2, 0);
    expect_pulse(11);
    applyStimulus(tm, cm, 22);
    checkDrained("test1");

    // Test 2: strobes at 10, 12, 13 queue behind the first pulse.
    doReset();
    tm = '0; cm = '0;
    tm[10] = 1'b1; tm[12] = 1'b1; tm[13] = 1'b1;
    expect_at(13, 2, 1); expect_at(14, 2, 2); expect_at(17, 2, 1); expect_at(23, 2, 0);
    expect_at(26, 3, 0); expect_at(28, 1, 1); expect_at(29, 1, 0);
    expect_pulse(11); expect_pulse(17); expect_pulse(23);
    applyStimulus(tm, cm, 32);
    checkDrained("test2");

    // Test 3: strobe held 10..14 saturates the queue and sets overflow.
    doReset();
    tm = '0; cm = '0;
    tm[14:10] = '1;
    expect_at(11, 2, 0); expect_at(12, 2, 1); expect_at(13, 2, 2); expect_at(14, 2, 3);
    expect_at(15, 2, 3); expect_at(14, 3, 0); expect_at(15, 3, 1);
    expect_at(17, 2, 2); expect_at(23, 2, 1); expect_at(29, 2, 0);
    expect_at(34, 1, 1); expect_at(35, 1, 0); expect_at(35, 3, 1);
    expect_pulse(11); expect_pulse(17); expect_pulse(23); expect_pulse(29);
    applyStimulus(tm, cm, 40);
    checkDrained("test3");

    // Test 4: overflow clear alone, then clear coincident with a new drop.
    doReset();
    tm = '0; cm = '0;
    tm[14:10] = '1; tm[17] = 1'b1; tm[18] = 1'b1;
    cm[16] = 1'b1; cm[18] = 1'b1;
    expect_at(15, 3, 1); expect_at(16, 3, 1); expect_at(17, 3, 0);
    expect_at(17, 2, 2); expect_at(18, 2, 3); expect_at(18, 3, 0);
    expect_at(19, 3, 1); expect_at(19, 2, 3); expect_at(20, 3, 1);
    expect_at(35, 2, 0); expect_at(41, 1, 0);
    expect_pulse(11); expect_pulse(17); expect_pulse(23); expect_pulse(29); expect_pulse(35);
    applyStimulus(tm, cm, 45);
    checkDrained("test4");

    // Test 5: asynchronous reset in the middle of a pulse, then a normal pulse afterwards.
    doReset();
    tm = '0; cm = '0;
    tm[10] = 1'b1; tm[11] = 1'b1;
    expect_at(12, 0, 1); expect_at(12, 1, 1); expect_at(12, 2, 1);
    applyStimulus(tm, cm, 12);
    #1 sys_rst = 1'b1;
    #1;
    checkOutput("async reset signal_out", int'(signal_out), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset pending", int'(pending), 0);
    checkOutput("async reset overflow", int'(overflow), 0);
    exp_q.delete();
    doReset();
    tm = '0; cm = '0;
    tm[3] = 1'b1;
    expect_at(3, 0, 0); expect_at(4, 0, 1); expect_at(4, 1, 1); expect_at(10, 1, 0);
    expect_pulse(4);
    applyStimulus(tm, cm, 12);
    checkDrained("test5");

    // Test 6: strobe on the last gap cycle is consumed directly without queuing.
    doReset();
    tm = '0; cm = '0;
    tm[10] = 1'b1; tm[16] = 1'b1;
    expect_at(16, 0, 0); expect_at(17, 0, 1); expect_at(17, 1, 1);
    expect_at(15, 2, 0); expect_at(17, 2, 0); expect_at(20, 2, 0);
    expect_at(22, 1, 1); expect_at(23, 1, 0);
    expect_pulse(11); expect_pulse(17);
    applyStimulus(tm, cm, 26);
    checkDrained("test6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
